// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and total-count helpers for the VGA timing generator.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    // Per-position control bits carried through the read-latency pipeline.
    typedef struct packed {
        logic sync_h;
        logic sync_v;
        logic act;
        logic h0;
        logic v0;
    } pix_ctl_t;

    function automatic int h_total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

    function automatic int v_total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync/active region decode, order sync, bp, active, fp.
module vga_axis_counter #(
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int CNT_W  = 11
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             in_sync,
    output logic             in_active
);
    localparam int              TOTAL = SYNC + BP + ACTIVE + FP;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    // Region bounds compared at int width so a full 2^CNT_W axis cannot alias.
    assign wrap      = tick && (count == LAST);
    assign in_sync   = int'(count) < SYNC;
    assign in_active = (int'(count) >= SYNC + BP) && (int'(count) < SYNC + BP + ACTIVE);

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            count <= '0;
        end else if (tick) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, h/v counters, address issue and
// a read-latency pipeline that re-aligns frame-buffer colour with syncs and DE.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int RD_LAT   = 1,
    parameter int COLOUR_W = 8,
    parameter int CNT_W    = 11
) (
    input  logic                CLK,
    input  logic                resetn,
    input  logic                en,
    input  logic [COLOUR_W-1:0] COLOUR_IN,
    output logic                pix_tick,
    output logic [CNT_W-1:0]    addrh,
    output logic [CNT_W-1:0]    addrv,
    output logic                addr_valid,
    output logic                hs,
    output logic                vs,
    output logic                de,
    output logic [COLOUR_W-1:0] cout,
    output logic                line_start,
    output logic                frame_start
);
    localparam int               H_TOTAL  = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int               V_TOTAL  = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam logic [CNT_W-1:0] H_ORG    = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_ORG    = CNT_W'(V_SYNC + V_BP);
    localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic             HS_ON    = 1'(HS_POL);
    localparam logic             VS_ON    = 1'(VS_POL);

    if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("vga_timing_gen: RD_LAT must be 1..4");
    end

    logic [3:0]       div;
    logic             adv;
    logic [CNT_W-1:0] h, v;
    logic             h_wrap, frame_wrap_unused;
    logic             h_sync, h_act, v_sync, v_act;
    pix_ctl_t         raw;
    pix_ctl_t         pipe [RD_LAT];
    pix_ctl_t         tail;

    // pix_tick is held (not cleared) while en=0 so a pending advance survives a pause.
    assign adv = pix_tick & en;

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else if (en) begin
            pix_tick <= (div == DIV_LAST);
            div      <= (div == DIV_LAST) ? '0 : div + 4'd1;
        end
    end

    vga_axis_counter #(
        .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CNT_W(CNT_W)
    ) u_h_cnt (
        .CLK(CLK), .resetn(resetn), .tick(adv),
        .count(h), .wrap(h_wrap), .in_sync(h_sync), .in_active(h_act)
    );

    vga_axis_counter #(
        .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CNT_W(CNT_W)
    ) u_v_cnt (
        .CLK(CLK), .resetn(resetn), .tick(h_wrap),
        .count(v), .wrap(frame_wrap_unused), .in_sync(v_sync), .in_active(v_act)
    );

    always_comb begin
        raw        = '0;
        raw.sync_h = h_sync;
        raw.sync_v = v_sync;
        raw.act    = h_act & v_act;
        raw.h0     = (h == '0);
        raw.v0     = (v == '0);
    end

    assign tail = pipe[RD_LAT-1];

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            addr_valid <= 1'b0;
            addrh      <= '0;
            addrv      <= '0;
        end else if (adv) begin
            addr_valid <= raw.act;
            addrh      <= raw.act ? h - H_ORG : '0;
            addrv      <= raw.act ? v - V_ORG : '0;
        end
    end

    // Reset entries are blank (no sync, no DE, not h0) so bubbles drive inactive outputs.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else if (adv) begin
            pipe[0] <= raw;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            de          <= 1'b0;
            cout        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (adv) begin
            hs          <= tail.sync_h ? HS_ON : ~HS_ON;
            vs          <= tail.sync_v ? VS_ON : ~VS_ON;
            de          <= tail.act;
            cout        <= tail.act ? COLOUR_IN : '0;
            line_start  <= tail.h0;
            frame_start <= tail.h0 & tail.v0;
        end else if (en) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small modes checked every cycle against a position-arithmetic model.
module tb_vga_timing_gen;

    localparam int   A_D = 1, A_LAT = 1;
    localparam int   A_HSY = 1, A_HBP = 1, A_HAC = 4, A_HFP = 1;
    localparam int   A_VSY = 1, A_VBP = 1, A_VAC = 2, A_VFP = 1;
    localparam logic A_HPOL = 1'b1, A_VPOL = 1'b0;

    localparam int   B_D = 3, B_LAT = 2;
    localparam int   B_HSY = 3, B_HBP = 2, B_HAC = 8, B_HFP = 2;
    localparam int   B_VSY = 1, B_VBP = 2, B_VAC = 4, B_VFP = 1;
    localparam logic B_HPOL = 1'b0, B_VPOL = 1'b1;

    typedef struct packed {
        logic        pix_tick;
        logic [10:0] addrh;
        logic [10:0] addrv;
        logic        addr_valid;
        logic        hs;
        logic        vs;
        logic        de;
        logic [7:0]  cout;
        logic        line_start;
        logic        frame_start;
    } obs_t;

    logic CLK = 1'b0;
    logic resetn, en;

    logic        tick_a, av_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic [10:0] ah_a, avr_a;
    logic [7:0]  col_a, cout_a;
    logic        tick_b, av_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [10:0] ah_b, avr_b;
    logic [7:0]  col_b, cout_b;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int n = 0, cyc = 0;
    bit track = 1'b0;
    int last_fs_a = -1, last_fs_b = -1;

    always #5 CLK = ~CLK;

    vga_timing_gen #(
        .H_ACTIVE(A_HAC), .H_FP(A_HFP), .H_SYNC(A_HSY), .H_BP(A_HBP),
        .V_ACTIVE(A_VAC), .V_FP(A_VFP), .V_SYNC(A_VSY), .V_BP(A_VBP),
        .HS_POL(1), .VS_POL(0), .CLK_DIV(A_D), .RD_LAT(A_LAT), .COLOUR_W(8), .CNT_W(11)
    ) u_dut_a (
        .CLK(CLK), .resetn(resetn), .en(en), .COLOUR_IN(col_a),
        .pix_tick(tick_a), .addrh(ah_a), .addrv(avr_a), .addr_valid(av_a),
        .hs(hs_a), .vs(vs_a), .de(de_a), .cout(cout_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HAC), .H_FP(B_HFP), .H_SYNC(B_HSY), .H_BP(B_HBP),
        .V_ACTIVE(B_VAC), .V_FP(B_VFP), .V_SYNC(B_VSY), .V_BP(B_VBP),
        .HS_POL(0), .VS_POL(1), .CLK_DIV(B_D), .RD_LAT(B_LAT), .COLOUR_W(8), .CNT_W(11)
    ) u_dut_b (
        .CLK(CLK), .resetn(resetn), .en(en), .COLOUR_IN(col_b),
        .pix_tick(tick_b), .addrh(ah_b), .addrv(avr_b), .addr_valid(av_b),
        .hs(hs_b), .vs(vs_b), .de(de_b), .cout(cout_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    // Frame-buffer models: colour = {row[3:0], col[3:0]}, junk 0xFF outside the active area.
    assign col_a = av_a ? {avr_a[3:0], ah_a[3:0]} : 8'hFF;

    always @(posedge CLK) begin
        if (!resetn)             col_b <= 8'hFF;
        else if (en && tick_b)   col_b <= av_b ? {avr_b[3:0], ah_b[3:0]} : 8'hFF;
    end

    // Expected outputs after n enabled clocks since reset, from raster arithmetic alone.
    function automatic obs_t model(input int nn, input int d, input int lat,
                                   input int hsy, input int hbp, input int hac, input int hfp,
                                   input int vsy, input int vbp, input int vac, input int vfp,
                                   input logic hpol, input logic vpol);
        obs_t e;
        int   ht, vt, t, k, h, v;
        bit   act, adv_last;
        ht = hsy + hbp + hac + hfp;
        vt = vsy + vbp + vac + vfp;
        e = '0;
        e.hs = ~hpol;
        e.vs = ~vpol;
        t = (nn >= 1) ? (nn - 1) / d : 0;
        e.pix_tick = (nn >= 1) && (nn % d == 0);
        if (t >= 1) begin
            k = t - 1;
            h = k % ht;
            v = (k / ht) % vt;
            act = (h >= hsy + hbp) && (h < hsy + hbp + hac) && (v >= vsy + vbp) && (v < vsy + vbp + vac);
            e.addr_valid = act;
            if (act) begin
                e.addrh = 11'(h - hsy - hbp);
                e.addrv = 11'(v - vsy - vbp);
            end
        end
        adv_last = (nn >= 2) && ((nn - 1) % d == 0);
        if (t >= lat + 1) begin
            k = t - 1 - lat;
            h = k % ht;
            v = (k / ht) % vt;
            act = (h >= hsy + hbp) && (h < hsy + hbp + hac) && (v >= vsy + vbp) && (v < vsy + vbp + vac);
            e.hs = (h < hsy) ? hpol : ~hpol;
            e.vs = (v < vsy) ? vpol : ~vpol;
            e.de = act;
            if (act) e.cout = 8'((((v - vsy - vbp) % 16) * 16) + ((h - hsy - hbp) % 16));
            e.line_start  = adv_last && (h == 0);
            e.frame_start = adv_last && (h == 0) && (v == 0);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_inst(input string who, input obs_t got, input obs_t exp);
        chk({who, ".pix_tick"},    32'(got.pix_tick),    32'(exp.pix_tick));
        chk({who, ".addrh"},       32'(got.addrh),       32'(exp.addrh));
        chk({who, ".addrv"},       32'(got.addrv),       32'(exp.addrv));
        chk({who, ".addr_valid"},  32'(got.addr_valid),  32'(exp.addr_valid));
        chk({who, ".hs"},          32'(got.hs),          32'(exp.hs));
        chk({who, ".vs"},          32'(got.vs),          32'(exp.vs));
        chk({who, ".de"},          32'(got.de),          32'(exp.de));
        chk({who, ".cout"},        32'(got.cout),        32'(exp.cout));
        chk({who, ".line_start"},  32'(got.line_start),  32'(exp.line_start));
        chk({who, ".frame_start"}, 32'(got.frame_start), 32'(exp.frame_start));
    endtask

    task automatic step(input logic r, input logic e);
        obs_t got;
        @(negedge CLK);
        got = '{tick_a, ah_a, avr_a, av_a, hs_a, vs_a, de_a, cout_a, ls_a, fs_a};
        chk_inst("a", got, model(n, A_D, A_LAT, A_HSY, A_HBP, A_HAC, A_HFP,
                                 A_VSY, A_VBP, A_VAC, A_VFP, A_HPOL, A_VPOL));
        got = '{tick_b, ah_b, avr_b, av_b, hs_b, vs_b, de_b, cout_b, ls_b, fs_b};
        chk_inst("b", got, model(n, B_D, B_LAT, B_HSY, B_HBP, B_HAC, B_HFP,
                                 B_VSY, B_VBP, B_VAC, B_VFP, B_HPOL, B_VPOL));
        if (track && fs_a) begin
            if (last_fs_a >= 0) chk("a.frame_period", 32'(cyc - last_fs_a), 32'd35);
            last_fs_a = cyc;
        end
        if (track && fs_b) begin
            if (last_fs_b >= 0) chk("b.frame_period", 32'(cyc - last_fs_b), 32'd360);
            last_fs_b = cyc;
        end
        cyc++;
        resetn = r;
        en     = e;
        if (!r)     n = 0;
        else if (e) n++;
    endtask

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        n      = 0;
        // Reset with en low, then free-run across several frames of both modes.
        repeat (3) step(1'b0, 1'b0);
        track = 1'b1;
        repeat (800) step(1'b1, 1'b1);
        track = 1'b0;
        // Pause mid-line, resume.
        repeat (5) step(1'b1, 1'b0);
        repeat (40) step(1'b1, 1'b1);
        // One-cycle reset mid-frame, then restart from (0,0).
        step(1'b0, 1'b1);
        repeat (400) step(1'b1, 1'b1);
        // Random run/pause with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
        end
        step(1'b1, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
